iterative_alu: RTL and testbench
================================

Name: iterative_alu

Overview:
- Multi-cycle execute unit that sits directly downstream of the ALU decoder.
- Consumes the 4-bit ALUControl code and two operands, and returns a registered result with a start/done handshake.
- Logical, arithmetic and compare ops complete in one cycle; shifts run one bit per cycle to save area in the task core.
- Used by the multi-cycle datapath variant in place of the combinational ALU.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHW, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled on a rising clk edge only while busy=0.
- ALUControl  input  4  operation code from the ALU decoder.
- a  input  WIDTH  operand A (shift source).
- b  input  WIDTH  operand B; bits [SHW-1:0] are the shift amount.
- busy  output  1  high while a shift is iterating.
- done  output  1  one-cycle pulse; result, zero and illegal are valid from this cycle.
- result  output  WIDTH  registered result; holds until the next completion.
- zero  output  1  registered (result==0); updates together with result.
- illegal  output  1  registered; high if the completed op code was unsupported.

Behaviour:
- Reset:
  - Synchronous, active-high; wins over everything, including a start in the same cycle.
  - Next cycle: state=IDLE, busy=0, done=0, result=0, zero=1, illegal=0.
  - Reset mid-shift abandons the operation; no done pulse is produced.
- States: IDLE, SHIFT, DONE. busy=1 only in SHIFT. done=1 only in DONE.
- Start acceptance:
  - start is accepted in IDLE or DONE (busy=0).
  - On acceptance, a, b[SHW-1:0] and ALUControl are latched; later input changes have no effect.
  - start while busy=1 is ignored (no queueing).
- Opcodes:
  - 0000 add; 0010 sub (both modulo 2^WIDTH).
  - 0100 and; 0110 or; 1110 xor.
  - 1010 slt (signed); 1100 sltu (unsigned); compare result is 1 or 0, zero-extended.
  - 1000 sll; 1011 srl; 1111 sra (sra replicates a[WIDTH-1] into each vacated bit).
- Non-shift op, or shift with amount 0:
  - Accepted in cycle 0; next state is DONE; done=1 in cycle 1.
  - Shift by 0 returns a unchanged.
- Shift with amount k>0:
  - Accepted in cycle 0; state goes to SHIFT with an accumulator equal to a and a counter equal to k.
  - Each SHIFT edge shifts the accumulator by 1 and decrements the counter.
  - The edge that brings the counter to 0 moves the state to DONE.
  - busy=1 in cycles 1..k; done=1 in cycle k+1.
- Unsupported code (any value not listed above):
  - Latency 1; result=0, zero=1, illegal=1.
  - illegal is cleared by the next legal completion.
- DONE state:
  - If start is high, the new op is accepted (back-to-back); otherwise the state returns to IDLE.
  - done deasserts the following cycle unless the new op itself completes then (single-cycle ops give done high on consecutive cycles).
- Output timing: result, zero and illegal change only on the edge entering DONE; they are stable at all other times.
- Upper bits of b above SHW are ignored for shifts.

Test Plan:
- Add and sub:
  - add a=0x7FFFFFFF, b=1 -> done in cycle 1, result=0x80000000, zero=0, busy never high.
  - sub a=5, b=5 -> result=0, zero=1.
- Compares, with a=0xFFFFFFFF, b=1:
  - slt -> result=1.
  - sltu -> result=0.
  - xor with the same operands -> 0xFFFFFFFE.
- Shifts:
  - sra a=0x80000000, b=31 -> busy cycles 1..31, done cycle 32, result=0xFFFFFFFF.
  - srl with the same operands -> result=0x00000001.
  - sll a=1, b=0x25 -> done cycle 6, result=0x00000020.
- Ignored start and shift by 0:
  - sll a=3, b=4 started; start with add and new operands during SHIFT -> ignored; result=0x30 at cycle 5.
  - Shift by 0 (b=0x20) -> done cycle 1, result=a.
- Reset mid-operation:
  - reset in cycle 3 of an sra by 20 -> next cycle busy=0, done=0, result=0, zero=1; no later done pulse.
  - A subsequent add 2+3 -> result=5.
- Illegal code and back-to-back issue:
  - ALUControl=0001 -> done cycle 1, result=0, zero=1, illegal=1.
  - start with add 1+1 asserted in that DONE cycle -> done again the next cycle, result=2, illegal=0.

Source files
------------

// File: rtl/iterative_alu.sv
// -----------------------------------------------------------------------------
// iterative_alu
//   Multi-cycle execute unit for the multi-cycle datapath. Logical, arithmetic
//   and compare operations finish one cycle after being accepted. Shifts move
//   the accumulator one bit per cycle, so only a single-bit shifter is needed
//   instead of a full barrel shifter.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      request, accepted only while busy is low
//   ALUControl 4-bit operation code from the ALU decoder
//   a          operand A (shift source)
//   b          operand B; b[SHW-1:0] is the shift amount
//   busy       high while a shift is iterating
//   done       one-cycle completion pulse
//   result     registered result, held until the next completion
//   zero       registered (result == 0)
//   illegal    registered, high when the completed op code was unsupported
// -----------------------------------------------------------------------------
module iterative_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b1110;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1100;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_count;
  logic [3:0]       r_shiftOp;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;

  logic [WIDTH-1:0] w_value;
  logic             w_legal;
  logic             w_isShift;
  logic [SHW-1:0]   w_shiftAmt;
  logic [WIDTH-1:0] w_accStep;

  assign w_shiftAmt = b[SHW-1:0];

  // Single-cycle result for the operation presented on the inputs. Shift ops
  // return a unchanged here, which is exactly the answer for a shift by zero;
  // non-zero shifts are finished by the iterating accumulator instead.
  always_comb begin
    w_value   = '0;
    w_legal   = 1'b1;
    w_isShift = 1'b0;
    case (ALUControl)
      OP_ADD:  w_value = a + b;
      OP_SUB:  w_value = a - b;
      OP_AND:  w_value = a & b;
      OP_OR:   w_value = a | b;
      OP_XOR:  w_value = a ^ b;
      OP_SLT:  w_value = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_value = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL, OP_SRL, OP_SRA: begin
        w_value   = a;
        w_isShift = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // One-bit step of the latched shift; sra feeds the sign bit back in.
  always_comb begin
    w_accStep = r_acc;
    case (r_shiftOp)
      OP_SLL:  w_accStep = {r_acc[WIDTH-2:0], 1'b0};
      OP_SRL:  w_accStep = {1'b0, r_acc[WIDTH-1:1]};
      default: w_accStep = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
    endcase
  end

  // Control FSM with registered outputs. result/zero/illegal are written only
  // on the edge that enters DONE, so they hold steady at every other time.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_count   <= '0;
      r_shiftOp <= OP_ADD;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        SHIFT: begin
          r_acc   <= w_accStep;
          r_count <= r_count - SHW'(1);
          if (r_count == SHW'(1)) begin
            r_state   <= DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_result  <= w_accStep;
            r_zero    <= (w_accStep == '0);
            r_illegal <= 1'b0;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request (back-to-back issue).
          r_done <= 1'b0;
          r_state <= IDLE;
          if (start) begin
            if (w_isShift && (w_shiftAmt != '0)) begin
              r_state   <= SHIFT;
              r_busy    <= 1'b1;
              r_acc     <= a;
              r_count   <= w_shiftAmt;
              r_shiftOp <= ALUControl;
            end else begin
              r_state   <= DONE;
              r_done    <= 1'b1;
              r_result  <= w_legal ? w_value : '0;
              r_zero    <= w_legal ? (w_value == '0) : 1'b1;
              r_illegal <= ~w_legal;
            end
          end
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign result  = r_result;
  assign zero    = r_zero;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_iterative_alu.sv
// -----------------------------------------------------------------------------
// tb_iterative_alu
//   Directed-vector bench for iterative_alu. A behavioural model tracks the
//   expected outputs cycle by cycle from the operation rules (whole-word shift
//   operators and a simple latency countdown), and a compare process checks
//   every output against it each cycle. Directed runs also pin literal results
//   and completion cycles.
// -----------------------------------------------------------------------------
module tb_iterative_alu;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b1110;
  localparam logic [3:0] OP_SLT  = 4'b1010;
  localparam logic [3:0] OP_SLTU = 4'b1100;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1111;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  ALUControl;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  iterative_alu #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .ALUControl(ALUControl),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .result(result),
    .zero(zero),
    .illegal(illegal)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the stimulus itself never completes
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one value and log a failure line on mismatch
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference result from the operation rules: {illegal, value}
  function automatic logic [32:0] refAlu(input logic [3:0] op, input logic [31:0] x,
                                         input logic [31:0] y);
    int k;
    k = int'(y[4:0]);
    case (op)
      OP_ADD:  return {1'b0, x + y};
      OP_SUB:  return {1'b0, x - y};
      OP_AND:  return {1'b0, x & y};
      OP_OR:   return {1'b0, x | y};
      OP_XOR:  return {1'b0, x ^ y};
      OP_SLT:  return {1'b0, (($signed(x) < $signed(y)) ? 32'd1 : 32'd0)};
      OP_SLTU: return {1'b0, ((x < y) ? 32'd1 : 32'd0)};
      OP_SLL:  return {1'b0, x << k};
      OP_SRL:  return {1'b0, x >> k};
      OP_SRA:  return {1'b0, 32'($signed(x) >>> k)};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  // Model state: expected outputs plus cycles remaining on a pending shift
  logic        mValid = 1'b0;
  int          mWait  = 0;
  logic [32:0] mPend;
  logic        mBusy, mDone, mZero, mIll;
  logic [31:0] mRes;

  // Behavioural model, advanced on each rising edge from the sampled inputs
  always @(posedge clk) begin
    logic [32:0] r;
    if (reset) begin
      mValid = 1'b1;
      mWait  = 0;
      mBusy  = 1'b0;
      mDone  = 1'b0;
      mRes   = 32'd0;
      mZero  = 1'b1;
      mIll   = 1'b0;
    end else if (mValid) begin
      mDone = 1'b0;
      if (mWait > 0) begin
        mWait = mWait - 1;
        if (mWait == 0) begin
          mBusy = 1'b0;
          mDone = 1'b1;
          mRes  = mPend[31:0];
          mIll  = mPend[32];
          mZero = (mPend[31:0] == 32'd0);
        end
      end else if (start) begin
        r = refAlu(ALUControl, a, b);
        if ((ALUControl == OP_SLL || ALUControl == OP_SRL || ALUControl == OP_SRA)
            && b[4:0] != 5'd0) begin
          mWait = int'(b[4:0]);
          mBusy = 1'b1;
          mPend = r;
        end else begin
          mDone = 1'b1;
          mRes  = r[31:0];
          mIll  = r[32];
          mZero = (r[31:0] == 32'd0);
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (mValid) begin
      checkOutput("cmp busy", 32'(busy), 32'(mBusy));
      checkOutput("cmp done", 32'(done), 32'(mDone));
      checkOutput("cmp result", result, mRes);
      checkOutput("cmp zero", 32'(zero), 32'(mZero));
      checkOutput("cmp illegal", 32'(illegal), 32'(mIll));
    end
  end

  // Present one request for the accepting edge, then scramble the inputs so a
  // design that fails to latch them would be caught. Ends #2 into cycle 1.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] opA,
                               input logic [31:0] opB);
    start      = 1'b1;
    ALUControl = op;
    a          = opA;
    b          = opB;
    @(posedge clk);
    #2;
    start      = 1'b0;
    a          = ~opA;
    b          = opB ^ 32'h0000_0005;
    ALUControl = op ^ 4'h3;
  endtask

  // Advance until done is seen, bounded; returns the cycle number it rose in
  task automatic waitDone(input int fromCycle, output int cyc);
    cyc = fromCycle;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #2;
      cyc++;
    end
  endtask

  task automatic runOp(input string name, input logic [3:0] op, input logic [31:0] opA,
                       input logic [31:0] opB, input int expCycle,
                       input logic [31:0] expRes, input logic expIll);
    int cyc;
    applyStimulus(op, opA, opB);
    waitDone(1, cyc);
    checkOutput({name, " doneCycle"}, 32'(cyc), 32'(expCycle));
    checkOutput({name, " result"}, result, expRes);
    checkOutput({name, " zero"}, 32'(zero), 32'(expRes == 32'd0));
    checkOutput({name, " illegal"}, 32'(illegal), 32'(expIll));
  endtask

  initial begin
    int cyc;
    reset      = 1'b1;
    start      = 1'b0;
    ALUControl = OP_ADD;
    a          = 32'd0;
    b          = 32'd0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset result", result, 32'd0);
    checkOutput("reset zero", 32'(zero), 32'd1);
    checkOutput("reset illegal", 32'(illegal), 32'd0);
    @(posedge clk);
    #2;

    $display("[TB] add / sub / logic / compare");
    runOp("add ovf", OP_ADD, 32'h7FFF_FFFF, 32'd1, 1, 32'h8000_0000, 1'b0);
    runOp("sub eq", OP_SUB, 32'd5, 32'd5, 1, 32'd0, 1'b0);
    runOp("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 1, 32'd1, 1'b0);
    runOp("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 1'b0);
    runOp("xor", OP_XOR, 32'hFFFF_FFFF, 32'd1, 1, 32'hFFFF_FFFE, 1'b0);
    runOp("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 1, 32'h00F0_1200, 1'b0);
    runOp("or", OP_OR, 32'hF000_0001, 32'h0000_0F00, 1, 32'hF000_0F01, 1'b0);

    $display("[TB] shifts");
    runOp("sra31", OP_SRA, 32'h8000_0000, 32'd31, 32, 32'hFFFF_FFFF, 1'b0);
    runOp("srl31", OP_SRL, 32'h8000_0000, 32'd31, 32, 32'h0000_0001, 1'b0);
    runOp("sll hiB", OP_SLL, 32'd1, 32'h25, 6, 32'h0000_0020, 1'b0);
    runOp("sra pos", OP_SRA, 32'h4000_0000, 32'd3, 4, 32'h0800_0000, 1'b0);

    $display("[TB] ignored start during shift, shift by zero");
    applyStimulus(OP_SLL, 32'd3, 32'd4);
    @(posedge clk);
    #2;
    start      = 1'b1;
    ALUControl = OP_ADD;
    a          = 32'd7;
    b          = 32'd9;
    @(posedge clk);
    #2;
    start = 1'b0;
    waitDone(3, cyc);
    checkOutput("ignored doneCycle", 32'(cyc), 32'd5);
    checkOutput("ignored result", result, 32'h30);
    @(posedge clk);
    #2;
    checkOutput("ignored noSecondDone", 32'(done), 32'd0);
    runOp("sll by 0", OP_SLL, 32'h1234_ABCD, 32'h20, 1, 32'h1234_ABCD, 1'b0);

    $display("[TB] reset mid-shift");
    applyStimulus(OP_SRA, 32'h8000_0000, 32'd20);
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    checkOutput("midReset busy", 32'(busy), 32'd0);
    checkOutput("midReset done", 32'(done), 32'd0);
    checkOutput("midReset result", result, 32'd0);
    checkOutput("midReset zero", 32'(zero), 32'd1);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #2;
      checkOutput("midReset noDone", 32'(done), 32'd0);
    end
    runOp("add after reset", OP_ADD, 32'd2, 32'd3, 1, 32'd5, 1'b0);

    $display("[TB] illegal code and back-to-back issue");
    @(posedge clk);
    #2;
    runOp("illegal", 4'b0001, 32'h1234_5678, 32'h9ABC_DEF0, 1, 32'd0, 1'b1);
    runOp("b2b add", OP_ADD, 32'd1, 32'd1, 1, 32'd2, 1'b0);
    runOp("b2b sub", OP_SUB, 32'd10, 32'd3, 1, 32'd7, 1'b0);
    repeat (3) @(posedge clk);
    #2;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
